// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: the op encoding,
// the FSM states and the decode from R-type funct codes onto md_op_t.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef struct packed {
        logic   valid;
        md_op_t op;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [5:0] funct);
        md_dec_t d;
        d.valid = 1'b1;
        d.op    = MD_MULT;
        case (funct)
            FN_MULT:  d.op = MD_MULT;
            FN_MULTU: d.op = MD_MULTU;
            FN_DIV:   d.op = MD_DIV;
            FN_DIVU:  d.op = MD_DIVU;
            FN_MTHI:  d.op = MD_MTHI;
            FN_MTLO:  d.op = MD_MTLO;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath of the sequencer: one shared 2*WIDTH accumulator that is either the
// shift-add product or the {remainder, quotient} pair of a restoring divide.
module muldiv_core
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               iterate,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    // Multiply keeps the multiplier in the low half and shifts it out as product
    // bits arrive; divide shifts the dividend out of the low half into the remainder.
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (load) begin
            div_d = is_div;
            if (is_div) begin
                acc_d  = {{WIDTH{1'b0}}, opa};
                opnd_d = opb;
            end else begin
                acc_d  = {{WIDTH{1'b0}}, opb};
                opnd_d = opa;
            end
        end else if (iterate) begin
            if (div_q) begin
                acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: accepts mul/div/MTHI/MTLO, sequences the one-bit-per-cycle core,
// applies sign fixup and writes HI/LO with a one-cycle done pulse.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             accept,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               div_q, div_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               bzero_q, bzero_d;

    md_op_t             op_e;
    logic               op_signed, op_div, op_md;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load, iterate;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_e      = md_op_t'(op);
    assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign op_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
    assign op_md     = (op_e == MD_MULT) || (op_e == MD_MULTU) || op_div;
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    assign accept = start && (state_q == ST_IDLE) && !flush;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_FIX) && !flush;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Unsigned ops latch zero signs, so the fixup below is a no-op for them.
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc : acc;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .iterate (iterate),
        .is_div  (op_div),
        .opa     (a_mag),
        .opb     (b_mag),
        .acc     (acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_raw_d  = a_raw_q;
        div_d    = div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        load     = 1'b0;
        iterate  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e == MD_MTHI) begin
                        hi_d = a;
                    end else if (op_e == MD_MTLO) begin
                        lo_d = a;
                    end else if (op_md) begin
                        load     = 1'b1;
                        a_raw_d  = a;
                        div_d    = op_div;
                        sign_a_d = op_signed && a[WIDTH-1];
                        sign_b_d = op_signed && b[WIDTH-1];
                        bzero_d  = op_div && (b == '0);
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    iterate = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (bzero_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_raw_q  <= '0;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_raw_q  <= a_raw_d;
            div_q    <= div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed and random bench for hilo_muldiv_ctrl: expected {hi,lo} pairs are queued
// at accept and popped once the edge after done has written HI/LO.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        accept, busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .accept (accept),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] px, py;
        logic signed [31:0] sx, sy, sq, sr;
        px = {{32{x[31]}}, x};
        py = {{32{y[31]}}, y};
        sx = x;
        sy = y;
        model = '0;
        case (o)
            MD_MULTU: model = {32'b0, x} * {32'b0, y};
            MD_MULT:  model = px * py;
            MD_DIVU:  model = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            MD_DIV: begin
                if (y == 0) model = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    model = {sr, sq};
                end
            end
            default: model = '0;
        endcase
    endfunction

    // driver: caller is just past a negedge; returns just past a negedge
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] expv);
        int cyc;
        logic [63:0] got;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk({tag, "_accept"}, {63'b0, accept}, 64'd1);
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        @(negedge clk);
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_hilo"}, {hi, lo}, got);
        chk({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        int cyc;
        int bad_accepts;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        #1;
        chk("reset_outputs", {61'b0, accept, busy, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_hilo", {hi, lo}, 64'd0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_op("divu_7_2",  MD_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003);
        run_op("div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_z",    MD_DIVU,  32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF);
        run_op("div_z",     MD_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF);

        // MTHI then a DIV squashed in its 10th RUN cycle
        start = 1'b1; op = MD_MTHI; a = 32'hA; b = '0;
        #1;
        chk("mthi_accept", {63'b0, accept}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hilo", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
        chk("mthi_idle", {62'b0, busy, done}, 64'd0);
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        #1;
        chk("flushdiv_accept", {63'b0, accept}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_run", {62'b0, busy, done}, 64'd2);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {62'b0, busy, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
        run_op("multu_2_3", MD_MULTU, 32'd2, 32'd3, 64'h0000_0000_0000_0006);

        start = 1'b1; op = MD_MTLO; a = 32'h55;
        #1;
        chk("mtlo_accept", {63'b0, accept}, 64'd1);
        @(negedge clk);
        op = 3'd7; a = 32'h99; b = 32'h77;
        #1;
        chk("mtlo_hilo", {hi, lo}, 64'h0000_0000_0000_0055);
        chk("unk_accept", {63'b0, accept}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("unk_state", {62'b0, busy, done}, 64'd0);
        chk("unk_hilo", {hi, lo}, 64'h0000_0000_0000_0055);
        start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd4; b = 32'd4;
        #1;
        chk("flush_start_accept", {63'b0, accept}, 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'h0000_0013;
            run_op("random", ro, ra, rb, model(ro, ra, rb));
        end

        // start held through busy: only re-accepted in the cycle after done
        start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
        #1;
        chk("held_first_accept", {63'b0, accept}, 64'd1);
        exp_q.push_back(64'd30);
        bad_accepts = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
            if (accept !== 1'b0) bad_accepts++;
        end while (done !== 1'b1 && cyc < 100);
        chk("held_latency", 64'(cyc), 64'd33);
        chk("held_no_accept_busy", 64'(bad_accepts), 64'd0);
        @(negedge clk);
        #1;
        chk("held_hilo", {hi, lo}, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);
        chk("held_reaccept", {63'b0, accept}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_run_busy", {63'b0, busy}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_busy", {62'b0, busy, done}, 64'd0);
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
